// File: rtl/tdc_thermo_encoder.sv
// rtl/tdc_thermo_encoder.sv - TDC thermometer hit detect, bubble filter and popcount encoder
// Fixed 4-clock pipeline from tap capture to fine_code/fine_valid.
module tdc_thermo_encoder #(
  parameter int TAPS        = 400,
  parameter int GROUP       = 20,
  parameter int DEAD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TAPS-1:0] step_data,
  output logic            fine_valid,
  output logic [8:0]      fine_code,
  output logic            fine_ovf,
  output logic [15:0]     hit_cnt
);

  localparam int NP = TAPS / GROUP;
  localparam int NS = (NP + 4) / 5;
  localparam int PW = $clog2(GROUP + 1);
  localparam int SW = $clog2(5 * GROUP + 1);
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  logic [TAPS-1:0] r_s0;
  logic            r_prev0;
  logic [DW-1:0]   r_dead;
  logic [TAPS-1:0] r_b;
  logic            r_hit1, r_ovf1;
  logic [PW-1:0]   r_part [NP];
  logic            r_hit2, r_ovf2;
  logic [SW-1:0]   r_sum [NS];
  logic            r_hit3, r_ovf3;

  logic            w_hit;
  logic [TAPS+1:0] w_ext;
  logic [TAPS-1:0] w_b;
  logic [PW-1:0]   w_part [NP];
  logic [SW-1:0]   w_sum [NS];
  logic [8:0]      w_total;

  assign w_hit = r_s0[0] & ~r_prev0 & (r_dead == '0);

  // Edge taps replicate themselves so the ends of the line never get voted away.
  assign w_ext = {r_s0[TAPS-1], r_s0, r_s0[0]};

  always_comb begin
    w_b = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_b[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_part[p] = '0;
      for (int k = 0; k < GROUP; k++) begin
        w_part[p] = w_part[p] + PW'(r_b[p*GROUP+k]);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      w_sum[s] = '0;
      for (int j = 0; j < 5; j++) begin
        if (s * 5 + j < NP) begin
          w_sum[s] = w_sum[s] + SW'(r_part[s*5+j]);
        end
      end
    end
  end

  always_comb begin
    w_total = '0;
    for (int s = 0; s < NS; s++) begin
      w_total = w_total + 9'(r_sum[s]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0    <= '0;
      r_prev0 <= 1'b0;
      r_dead  <= '0;
      r_b     <= '0;
      r_hit1  <= 1'b0;
      r_ovf1  <= 1'b0;
      r_hit2  <= 1'b0;
      r_ovf2  <= 1'b0;
      r_hit3  <= 1'b0;
      r_ovf3  <= 1'b0;
      for (int p = 0; p < NP; p++) r_part[p] <= '0;
      for (int s = 0; s < NS; s++) r_sum[s] <= '0;
    end else begin
      r_s0    <= step_data;
      r_prev0 <= r_s0[0];
      if (w_hit) begin
        r_dead <= DW'(DEAD_CYCLES);
      end else if (r_dead != '0) begin
        r_dead <= r_dead - 1'b1;
      end
      r_b    <= w_b;
      r_hit1 <= w_hit;
      r_ovf1 <= r_s0[TAPS-1];
      for (int p = 0; p < NP; p++) r_part[p] <= w_part[p];
      r_hit2 <= r_hit1;
      r_ovf2 <= r_ovf1;
      for (int s = 0; s < NS; s++) r_sum[s] <= w_sum[s];
      r_hit3 <= r_hit2;
      r_ovf3 <= r_ovf2;
    end
  end

  // Output stage holds code/ovf between strobes for the combiner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine_valid <= 1'b0;
      fine_code  <= '0;
      fine_ovf   <= 1'b0;
      hit_cnt    <= '0;
    end else begin
      fine_valid <= r_hit3;
      if (r_hit3) begin
        fine_code <= r_ovf3 ? 9'(TAPS) : w_total;
        fine_ovf  <= r_ovf3;
        hit_cnt   <= hit_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// tb/tb_tdc_thermo_encoder.sv - self-checking bench for tdc_thermo_encoder
module tb_tdc_thermo_encoder;

  localparam int TAPS = 400;
  localparam int DEAD = 4;
  localparam int LAT  = 4;

  typedef struct {
    bit v;
    int code;
    bit ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [TAPS-1:0] step_data = '0;
  logic            fine_valid;
  logic [8:0]      fine_code;
  logic            fine_ovf;
  logic [15:0]     hit_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int strobes = 0;

  exp_t q[$];
  int   m_cyc, m_last, m_code, m_cnt;
  bit   m_prev, m_ovf;

  tdc_thermo_encoder #(.TAPS(TAPS), .GROUP(20), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .step_data(step_data),
    .fine_valid(fine_valid), .fine_code(fine_code), .fine_ovf(fine_ovf), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [TAPS-1:0] therm(input int n);
    logic [TAPS-1:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  // Majority-voted count of ones; a front past the last tap reads as full scale.
  function automatic int ref_code(input logic [TAPS-1:0] w);
    int c;
    int l, r;
    if (w[TAPS-1]) return TAPS;
    c = 0;
    for (int i = 0; i < TAPS; i++) begin
      l = (i == 0) ? int'(w[0]) : int'(w[i-1]);
      r = (i == TAPS-1) ? int'(w[TAPS-1]) : int'(w[i+1]);
      if (l + int'(w[i]) + r >= 2) c++;
    end
    return c;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cyc  = 0;
    m_last = -1000;
    m_prev = 1'b0;
    m_code = 0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endfunction

  task automatic step(input logic [TAPS-1:0] w);
    exp_t e;
    bit   ev;
    step_data = w;
    @(posedge clk);
    #1;
    e.v = w[0] && !m_prev && (m_cyc - m_last > DEAD);
    if (e.v) m_last = m_cyc;
    m_prev = w[0];
    m_cyc++;
    e.code = ref_code(w);
    e.ovf  = w[TAPS-1];
    q.push_back(e);
    ev = 1'b0;
    if (q.size() > LAT) begin
      e = q.pop_front();
      ev = e.v;
      if (e.v) begin
        m_code = e.code;
        m_ovf  = e.ovf;
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end
    if (fine_valid === 1'b1) strobes++;
    chk("fine_valid", 16'(fine_valid), 16'(ev));
    chk("fine_code", 16'(fine_code), 16'(m_code));
    chk("fine_ovf", 16'(fine_ovf), 16'(m_ovf));
    chk("hit_cnt", hit_cnt, 16'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 16'(fine_valid), 16'd0);
    chk({tag, "_code"}, 16'(fine_code), 16'd0);
    chk({tag, "_ovf"}, 16'(fine_ovf), 16'd0);
    chk({tag, "_cnt"}, hit_cnt, 16'd0);
  endtask

  initial begin
    logic [TAPS-1:0] w;
    int base;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(3);

    // clean thermometer
    strobes = 0;
    step('0);
    step(therm(137));
    idle(3);
    chk("clean_latency_pre", 16'(fine_valid), 16'd0);
    step('0);
    chk("clean_latency_strobe", 16'(fine_valid), 16'd1);
    chk("clean_code", 16'(fine_code), 16'd137);
    chk("clean_ovf", 16'(fine_ovf), 16'd0);
    chk("clean_cnt", hit_cnt, 16'd1);
    idle(4);

    // bubble
    w = therm(200);
    w[120] = 1'b0;
    w[205] = 1'b1;
    step(w);
    idle(8);
    chk("bubble_code", 16'(fine_code), 16'd200);

    // overflow
    step('1);
    idle(8);
    chk("ovf_code", 16'(fine_code), 16'd400);
    chk("ovf_flag", 16'(fine_ovf), 16'd1);

    // hold-off
    base = int'(hit_cnt);
    strobes = 0;
    step(therm(50));
    step('0);
    step(therm(80));
    idle(4);
    chk("holdoff_first_code", 16'(fine_code), 16'd50);
    step(therm(90));
    idle(8);
    chk("holdoff_strobes", 16'(strobes), 16'd2);
    chk("holdoff_code", 16'(fine_code), 16'd90);
    chk("holdoff_cnt", hit_cnt, 16'(base + 2));

    // sustained level
    strobes = 0;
    repeat (20) step(therm(300));
    idle(8);
    chk("sustain_strobes", 16'(strobes), 16'd1);
    chk("sustain_code", 16'(fine_code), 16'd300);

    // reset mid-flight
    strobes = 0;
    step(therm(60));
    step('0);
    step('0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(8);
    chk("midrst_strobes", 16'(strobes), 16'd0);
    check_zero_outputs("midrst_after");
    step(therm(70));
    idle(6);
    chk("fresh_cnt", hit_cnt, 16'd1);
    chk("fresh_code", 16'(fine_code), 16'd70);

    // first capture after reset with tap 0 already high
    rst_n = 1'b0;
    step_data = therm(33);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(therm(33));
    idle(4);
    chk("post_reset_level_cnt", hit_cnt, 16'd1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        w = '0;
      end else if (r < 8) begin
        w = therm(int'($urandom_range(0, TAPS)));
        repeat ($urandom_range(0, 3)) w[$urandom_range(0, TAPS-1)] ^= 1'b1;
      end else begin
        for (int k = 0; k < TAPS; k += 32) begin
          logic [31:0] rnd;
          rnd = $urandom;
          for (int b = 0; b < 32 && k + b < TAPS; b++) w[k+b] = rnd[b];
        end
      end
      step(w);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
